alu_cmd_issuer: RTL and testbench

Initiator side of the team's 4-bit ALU interface (enable, A, B, 2-bit opcode, out).
- Accepts register-level commands over a valid/ready handshake.
- Fetches operands from a small internal register file and drives a combinational ALU for exactly one cycle.
- Writes the result back and returns it on a valid/ready response channel.
- Sits between a control sequencer/testbench and the ALU instance.

---
 rtl/alu_cmd_issuer_pkg.sv | 20 ++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_cmd_issuer.sv | 108 ++++++++++
 tb/tb_alu_cmd_issuer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer and the 4-bit ALU it drives:
// opcode encodings, issuer FSM states and default widths.
package alu_cmd_issuer_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned REG_AW_DEF = 2;
    localparam int unsigned OP_W       = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
    localparam logic [OP_W-1:0] OP_AND  = 2'b10;
    localparam logic [OP_W-1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: synchronous clear, one write port, two operand read
// ports and one debug read port, all reads combinational.
module alu_regfile
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_a_addr,
    input  logic [REG_AW-1:0] rd_b_addr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] rd_a_c,
    output logic [DATA_W-1:0] rd_b_c,
    output logic [DATA_W-1:0] dbg_c
);

    localparam int unsigned NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    // Reset has priority so an aborted command never lands its write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_a_c = regs[rd_a_addr];
    assign rd_b_c = regs[rd_b_addr];
    assign dbg_c  = regs[dbg_addr];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 4-bit ALU: accepts a register command, drives the ALU for
// one cycle, writes the result back and returns it on a response channel.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [REG_AW-1:0] cmd_srca,
    input  logic [REG_AW-1:0] cmd_srcb,
    input  logic [REG_AW-1:0] cmd_dst,
    output logic              alu_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              wr_en;

    // The ALU result is captured at the end of the single ISSUE cycle.
    assign wr_en = (state == ISSUE);

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (dst),
        .wr_data   (alu_out),
        .rd_a_addr (cmd_srca),
        .rd_b_addr (cmd_srcb),
        .dbg_addr  (dbg_addr),
        .rd_a_c    (rd_a),
        .rd_b_c    (rd_b),
        .dbg_c     (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dst        <= '0;
            cmd_ready  <= 1'b1;
            alu_en     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= OP_ADD;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are snapshot here, before any write-back of this command.
                    if (cmd_valid) begin
                        alu_a      <= cmd_imm_en ? cmd_imm : rd_a;
                        alu_b      <= rd_b;
                        alu_opcode <= cmd_op;
                        alu_en     <= 1'b1;
                        dst        <= cmd_dst;
                        cmd_ready  <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data   <= alu_out;
                    rsp_zero   <= (alu_out == '0);
                    rsp_valid  <= 1'b1;
                    alu_en     <= 1'b0;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    alu_opcode <= OP_ADD;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: hosts the ALU, drives directed and
// random commands, and checks ALU drive, responses and register contents.
module tb_alu_cmd_issuer;
    import alu_cmd_issuer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic [1:0] cmd_dst;
    logic       alu_en;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic [3:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_zero;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int bp_mode = 0;

    logic [3:0]  mregs [4];
    logic [9:0]  alu_q [$];
    logic [3:0]  rsp_q [$];

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .cmd_dst    (cmd_dst),
        .alu_en     (alu_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int s;
        case (op)
            2'b00:   s = (int'(a) + int'(b)) % 16;
            2'b01:   s = (int'(a) - int'(b) + 16) % 16;
            2'b10:   s = int'(a & b);
            default: s = int'(a);
        endcase
        return 4'(s);
    endfunction

    always_comb alu_out = alu_en ? ref_alu(alu_opcode, alu_a, alu_b) : 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // ALU-side monitor: one expected drive per accepted command.
    always @(negedge clk) begin
        if (alu_en) begin
            if (alu_q.size() == 0) begin
                check("alu_unexpected_en", 32'(alu_en), 32'd0);
            end else begin
                logic [9:0] e;
                e = alu_q.pop_front();
                check("alu_a", 32'(alu_a), 32'(e[9:6]));
                check("alu_b", 32'(alu_b), 32'(e[5:2]));
                check("alu_opcode", 32'(alu_opcode), 32'(e[1:0]));
            end
        end
    end

    // Response monitor: stability under backpressure, data, and ready recovery.
    bit         held = 1'b0;
    logic [3:0] held_data;
    bit         ack_prev = 1'b0;
    always @(negedge clk) begin
        if (ack_prev) check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        ack_prev = 1'b0;
        if (rsp_valid) begin
            if (held) check("rsp_data_stable", 32'(rsp_data), 32'(held_data));
            if (rsp_ready) begin
                check("cmd_ready_low_in_resp", 32'(cmd_ready), 32'd0);
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    logic [3:0] e;
                    e = rsp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e));
                    check("rsp_zero", 32'(rsp_zero), 32'(e == 4'h0));
                end
                ack_prev = 1'b1;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_data = rsp_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic dbg_check();
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            check("dbg_data", 32'(dbg_data), 32'(mregs[a]));
        end
    endtask

    task automatic issue(input logic [1:0] op, input bit imm_en, input logic [3:0] imm,
                         input logic [1:0] srca, input logic [1:0] srcb, input logic [1:0] dst,
                         input bit want_rsp);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        int n;
        bit got;
        @(posedge clk);
        #2;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_imm_en = imm_en;
        cmd_imm    = imm;
        cmd_srca   = srca;
        cmd_srcb   = srcb;
        cmd_dst    = dst;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            n++;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        a = imm_en ? imm : mregs[srca];
        b = mregs[srcb];
        r = ref_alu(op, a, b);
        alu_q.push_back({a, b, op});
        if (want_rsp) begin
            rsp_q.push_back(r);
            mregs[dst] = r;
        end
        @(posedge clk);
        #2;
        cmd_valid  = 1'b0;
        cmd_op     = 2'($urandom);
        cmd_imm_en = 1'($urandom);
        cmd_imm    = 4'($urandom);
        cmd_srca   = 2'($urandom);
        cmd_srcb   = 2'($urandom);
        cmd_dst    = 2'($urandom);
        @(negedge clk);
        check("issue_alu_en", 32'(alu_en), 32'd1);
        check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
        if (!want_rsp) return;
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("resp_alu_en", 32'(alu_en), 32'd0);
        check("resp_alu_a", 32'(alu_a), 32'd0);
        check("resp_alu_b", 32'(alu_b), 32'd0);
        check("resp_alu_opcode", 32'(alu_opcode), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_imm_en = 1'b0;
        cmd_imm    = 4'h0;
        cmd_srca   = 2'd0;
        cmd_srcb   = 2'd0;
        cmd_dst    = 2'd0;
        dbg_addr   = 2'd0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) mregs[i] = 4'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
        dbg_check();

        // Immediate load
        issue(OP_PASS, 1'b1, 4'h7, 2'd2, 2'd3, 2'd1, 1'b1);
        dbg_check();

        // Add with wrap to zero
        issue(OP_PASS, 1'b1, 4'hF, 2'd0, 2'd0, 2'd0, 1'b1);
        issue(OP_PASS, 1'b1, 4'h1, 2'd0, 2'd0, 2'd1, 1'b1);
        issue(OP_ADD,  1'b0, 4'h9, 2'd0, 2'd1, 2'd2, 1'b1);
        dbg_check();

        // Sub with destination aliasing a source, then AND
        issue(OP_PASS, 1'b1, 4'h2, 2'd0, 2'd0, 2'd0, 1'b1);
        issue(OP_PASS, 1'b1, 4'h5, 2'd0, 2'd0, 2'd1, 1'b1);
        issue(OP_SUB,  1'b0, 4'h0, 2'd0, 2'd1, 2'd0, 1'b1);
        issue(OP_AND,  1'b0, 4'h0, 2'd0, 2'd1, 2'd3, 1'b1);
        dbg_check();

        // Response backpressure with a competing command held on the input
        @(posedge clk);
        #1 bp_mode = 2;
        issue(OP_ADD, 1'b0, 4'h0, 2'd1, 2'd1, 2'd2, 1'b1);
        @(posedge clk);
        #2;
        cmd_valid  = 1'b1;
        cmd_op     = OP_PASS;
        cmd_imm_en = 1'b1;
        cmd_imm    = 4'hC;
        cmd_dst    = 2'd1;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_en", 32'(alu_en), 32'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        bp_mode   = 0;
        repeat (3) @(negedge clk);
        dbg_check();

        // Reset during the ISSUE cycle aborts the write and the response
        issue(OP_ADD, 1'b1, 4'h3, 2'd0, 2'd1, 2'd3, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid_rst", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mregs[i] = 4'h0;
        repeat (3) begin
            @(negedge clk);
            check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
            check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        dbg_check();

        // Random traffic with random response backpressure
        bp_mode = 1;
        for (int k = 0; k < 60; k++) begin
            issue(2'($urandom), 1'($urandom), 4'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom), 1'b1);
            if (k % 8 == 7) dbg_check();
        end

        bp_mode = 0;
        n = 0;
        while (rsp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("alu_queue_drained", 32'(alu_q.size()), 32'd0);
        dbg_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
